// File: rtl/guess_attempt_ctrl.sv
// Attempt controller between the switch/button front end and the comparator:
// latches a guess, runs one enable/result handshake, times the response and enforces lockout.
module guess_attempt_ctrl #(
    parameter int unsigned MAX_FAILS      = 5,
    parameter int unsigned LOCKOUT_CYCLES = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        submit,
    input  logic [7:0]  guess_sw,
    input  logic        cmp_success,
    input  logic        cmp_fail,
    output logic        cmp_enable,
    output logic [7:0]  guess_value,
    output logic        busy,
    output logic        last_pass,
    output logic        last_fail,
    output logic        last_timeout,
    output logic [7:0]  last_cycles,
    output logic [7:0]  fail_streak,
    output logic [15:0] attempts,
    output logic        locked
);

    localparam int unsigned     LOCK_W      = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [7:0]      TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);
    localparam logic [7:0]      MAX_FAILS_V = 8'(MAX_FAILS);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RELEASE,
        S_LOCKOUT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [7:0]          lat_cnt;
    logic                rel_phase;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [15:0]         attempt_cnt;

    logic                accept;
    logic                res_pass;
    logic                res_fail;
    logic                res_timeout;
    logic                lock_done;

    // All handshake outputs decode the state register, so none depend on inputs.
    assign cmp_enable = (state == S_LAUNCH) || (state == S_WAIT);
    assign busy       = (state != S_IDLE);
    assign locked     = (state == S_LOCKOUT);
    assign attempts   = attempt_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        res_pass    = 1'b0;
        res_fail    = 1'b0;
        res_timeout = 1'b0;
        lock_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (submit) begin
                    accept     = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // Flags below count 3 predate the comparator seeing enable.
                if (lat_cnt >= 8'd3) begin
                    if (cmp_success) begin
                        res_pass = 1'b1;
                    end else if (cmp_fail) begin
                        res_fail = 1'b1;
                    end else if (lat_cnt == TIMEOUT_VAL) begin
                        res_timeout = 1'b1;
                    end
                end
                if (res_pass || res_fail || res_timeout) begin
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (rel_phase) begin
                    state_next = (fail_streak >= MAX_FAILS_V) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (lock_cnt == LOCK_LAST) begin
                    lock_done  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            guess_value  <= '0;
            last_pass    <= 1'b0;
            last_fail    <= 1'b0;
            last_timeout <= 1'b0;
            last_cycles  <= '0;
            fail_streak  <= '0;
            attempt_cnt  <= '0;
            lat_cnt      <= '0;
            rel_phase    <= 1'b0;
            lock_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        guess_value  <= guess_sw;
                        attempt_cnt  <= attempt_cnt + 16'd1;
                        last_pass    <= 1'b0;
                        last_fail    <= 1'b0;
                        last_timeout <= 1'b0;
                        lat_cnt      <= 8'd1;
                    end
                end
                S_LAUNCH: begin
                    lat_cnt <= lat_cnt + 8'd1;
                end
                S_WAIT: begin
                    if (res_pass) begin
                        last_pass   <= 1'b1;
                        last_cycles <= lat_cnt;
                        fail_streak <= '0;
                        rel_phase   <= 1'b0;
                    end else if (res_fail || res_timeout) begin
                        last_fail    <= 1'b1;
                        last_timeout <= res_timeout;
                        last_cycles  <= lat_cnt;
                        rel_phase    <= 1'b0;
                        if (fail_streak != 8'hFF) begin
                            fail_streak <= fail_streak + 8'd1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                S_RELEASE: begin
                    rel_phase <= 1'b1;
                    if (rel_phase) begin
                        rel_phase <= 1'b0;
                        lock_cnt  <= LOCK_LOAD;
                    end
                end
                S_LOCKOUT: begin
                    if (lock_done) begin
                        fail_streak <= '0;
                        lock_cnt    <= '0;
                    end else begin
                        lock_cnt <= lock_cnt - LOCK_LAST;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_attempt_ctrl.sv
// Bench for guess_attempt_ctrl: a 2-bit-per-cycle comparator model drives the flags and a
// rule-level reference predicts latency, flags, streak, attempts and lockout length.
module tb_guess_attempt_ctrl;

    localparam int MAXF = 3;
    localparam int LOCK = 20;
    localparam int TMO  = 10;

    logic        clk;
    logic        rst;
    logic        submit;
    logic [7:0]  guess_sw;
    logic        cmp_success;
    logic        cmp_fail;
    logic        cmp_enable;
    logic [7:0]  guess_value;
    logic        busy;
    logic        last_pass;
    logic        last_fail;
    logic        last_timeout;
    logic [7:0]  last_cycles;
    logic [7:0]  fail_streak;
    logic [15:0] attempts;
    logic        locked;

    guess_attempt_ctrl #(
        .MAX_FAILS      (MAXF),
        .LOCKOUT_CYCLES (LOCK),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .submit       (submit),
        .guess_sw     (guess_sw),
        .cmp_success  (cmp_success),
        .cmp_fail     (cmp_fail),
        .cmp_enable   (cmp_enable),
        .guess_value  (guess_value),
        .busy         (busy),
        .last_pass    (last_pass),
        .last_fail    (last_fail),
        .last_timeout (last_timeout),
        .last_cycles  (last_cycles),
        .fail_streak  (fail_streak),
        .attempts     (attempts),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model: first enabled edge arms, then one bit pair (LSB first) per edge.
    logic [7:0] secret;
    int         step;
    logic       cm_s;
    logic       cm_f;
    logic       force_mode;
    logic       frc_s;
    logic       frc_f;

    always @(posedge clk) begin
        if (!cmp_enable) begin
            step <= 0;
            cm_s <= 1'b0;
            cm_f <= 1'b0;
        end else if (!cm_s && !cm_f) begin
            step <= step + 1;
            if (step >= 1 && step <= 4) begin
                if (guess_value[2*(step-1) +: 2] != secret[2*(step-1) +: 2]) cm_f <= 1'b1;
            end else if (step == 5) begin
                cm_s <= 1'b1;
            end
        end
    end

    assign cmp_success = force_mode ? frc_s : cm_s;
    assign cmp_fail    = force_mode ? frc_f : cm_f;

    int          ncomp;
    int          nfail;
    logic [15:0] m_attempts;
    int          m_streak;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency is set by the first differing bit pair; a full match needs all four pairs plus a step.
    function automatic int ref_latency(input logic [7:0] s, input logic [7:0] g);
        for (int i = 0; i < 4; i++) begin
            if (((s >> (2 * i)) & 8'h3) != ((g >> (2 * i)) & 8'h3)) return i + 3;
        end
        return 7;
    endfunction

    // mode 0: comparator model, 1: flags held low, 2: both flags high, 3: stale success for 2 cycles
    task automatic do_attempt(input logic [7:0] g, input int mode, input bit poke);
        int   exp_n;
        logic exp_pass;
        logic exp_to;
        int   edges;
        int   lk;
        if (mode == 1 || mode == 3) begin
            exp_pass = 1'b0; exp_to = 1'b1; exp_n = TMO;
        end else if (mode == 2) begin
            exp_pass = 1'b1; exp_to = 1'b0; exp_n = 3;
        end else begin
            exp_n = ref_latency(secret, g); exp_pass = (g == secret); exp_to = 1'b0;
        end
        force_mode = (mode != 0);
        frc_s      = (mode == 2 || mode == 3);
        frc_f      = (mode == 2);
        guess_sw   = g;
        submit     = 1'b1;
        @(posedge clk); #1;
        submit     = 1'b0;
        guess_sw   = 8'($urandom);
        m_attempts = m_attempts + 16'd1;
        check("enable_on_launch", cmp_enable, 1);
        check("guess_latched", guess_value, g);
        check("busy_on_launch", busy, 1);
        check("pass_cleared", last_pass, 0);
        check("fail_cleared", last_fail, 0);
        edges = 0;
        while (!(last_pass || last_fail) && edges < 300) begin
            if (mode == 3 && edges == 2) frc_s = 1'b0;
            submit = (poke && edges == 1);
            @(posedge clk); #1;
            edges++;
        end
        submit = 1'b0;
        if (exp_pass) m_streak = 0;
        else if (m_streak < 255) m_streak++;
        check("result_edge", edges, exp_n);
        check("last_cycles", last_cycles, exp_n);
        check("last_pass", last_pass, exp_pass);
        check("last_fail", last_fail, !exp_pass);
        check("last_timeout", last_timeout, exp_to);
        check("enable_off_at_result", cmp_enable, 0);
        check("fail_streak", fail_streak, m_streak);
        check("attempts", attempts, m_attempts);
        force_mode = 1'b0;
        @(posedge clk); #1;
        check("busy_release2", busy, 1);
        check("enable_release2", cmp_enable, 0);
        @(posedge clk); #1;
        if (m_streak >= MAXF) begin
            check("locked_entry", locked, 1);
            lk = 0;
            while (locked && lk < 100) begin
                submit = (lk == 5);
                @(posedge clk); #1;
                lk++;
            end
            submit   = 1'b0;
            m_streak = 0;
            check("lockout_len", lk, LOCK);
            check("streak_after_lock", fail_streak, 0);
            check("attempts_lock", attempts, m_attempts);
        end else begin
            check("locked_none", locked, 0);
        end
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ncomp = 0; nfail = 0;
        m_attempts = '0; m_streak = 0;
        rst = 1'b0; submit = 1'b0; guess_sw = 8'h5A;
        secret = 8'hA5; force_mode = 1'b0; frc_s = 1'b0; frc_f = 1'b0;

        for (int i = 0; i < 4; i++) begin
            submit = i[0];
            @(posedge clk); #1;
            check("rst_enable", cmp_enable, 0);
            check("rst_outputs", {busy, locked, last_pass, last_fail, last_timeout}, 0);
            check("rst_values", {guess_value, last_cycles, fail_streak, attempts}, 0);
        end
        submit = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        do_attempt(8'hA5, 0, 0);
        do_attempt(8'hA4, 0, 0);
        do_attempt(8'hA1, 0, 1);
        do_attempt(8'h85, 0, 0);
        do_attempt(8'h25, 0, 0);
        do_attempt(8'hA5, 0, 0);

        do_attempt(8'h00, 0, 0);
        do_attempt(8'h11, 0, 0);
        do_attempt(8'h5A, 0, 0);
        do_attempt(8'hA5, 0, 0);

        do_attempt(8'h3C, 1, 0);
        do_attempt(8'hA5, 3, 0);
        do_attempt(8'h12, 2, 0);

        // Reset in the middle of WAIT
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_attempts = '0; m_streak = 0;
        guess_sw = 8'hA5; submit = 1'b1;
        @(posedge clk); #1;
        submit = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wait_enable", cmp_enable, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_enable", cmp_enable, 0);
        check("midrst_busy", busy, 0);
        check("midrst_last", {last_pass, last_fail, last_timeout}, 0);
        check("midrst_cycles", last_cycles, 0);
        check("midrst_attempts", attempts, 0);
        @(posedge clk); #1;
        check("midrst_enable_hold", cmp_enable, 0);

        dut.attempt_cnt = 16'hFFFF;
        m_attempts = 16'hFFFF;
        do_attempt(8'hA5, 0, 0);
        check("attempts_wrap", attempts, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] g;
            int         mode;
            secret = 8'($urandom);
            g      = ($urandom_range(0, 3) == 0) ? secret : 8'($urandom);
            mode   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_attempt(g, mode, bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/guess_attempt_ctrl.md
# guess_attempt_ctrl

Sits between the debounced switch/button front end and the 2-bit-per-cycle comparator. Latches an 8-bit guess on a submit pulse, runs one enable/result handshake with the comparator, and measures the comparator's response latency in cycles, which is the timing leak the demo exposes. Tracks consecutive failures and enforces a timed lockout after too many. It also counts total attempts.

## Interface
- MAX_FAILS, 5: consecutive failures that trigger lockout (1..255)
- LOCKOUT_CYCLES, 100_000_000: lockout duration in clk cycles (≥1)
- TIMEOUT_CYCLES, 63: result wait limit in cycles (3..254)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- submit  in  1  single-cycle debounced pulse, request an attempt
- guess_sw  in  8  switch value, sampled on accepted submit
- cmp_success  in  1  comparator success flag (level, held)
- cmp_fail  in  1  comparator fail flag (level, held)
- cmp_enable  out  1  comparator enable
- guess_value  out  8  latched guess driven to comparator
- busy  out  1  high in any state except IDLE
- last_pass  out  1  last attempt matched
- last_fail  out  1  last attempt mismatched or timed out
- last_timeout  out  1  last attempt ended by timeout
- last_cycles  out  8  measured latency of last attempt
- fail_streak  out  8  consecutive failures
- attempts  out  16  total accepted attempts, wraps 0xFFFF→0
- locked  out  1  high during LOCKOUT

## Operation
- Reset (rst=0): state IDLE; every output 0; internal counters 0.
- IDLE: submit=1 → latch guess_sw into guess_value, attempts+1, clear last_pass/last_fail/last_timeout, latency counter←1, go LAUNCH. Submit in any other state is ignored (not queued).
- LAUNCH (1 cycle): cmp_enable=1; counter+1; go WAIT.
- WAIT: cmp_enable=1; counter+1 each cycle. Comparator flags are stale until it sees enable, so they are ignored while counter<3. From counter≥3:
  - cmp_success=1 → last_pass=1, last_cycles←counter, fail_streak←0, go RELEASE.
  - else cmp_fail=1 → last_fail=1, last_cycles←counter, fail_streak+1, saturating at 255, go RELEASE.
  - Both high at once: success wins.
  - counter==TIMEOUT_CYCLES with no flag → last_fail=1, last_timeout=1, last_cycles←TIMEOUT_CYCLES, fail_streak+1, go RELEASE.
- RELEASE (2 cycles): cmp_enable=0, which guarantees the comparator observes enable low and re-arms. After the 2nd cycle: if fail_streak≥MAX_FAILS go LOCKOUT, else IDLE.
- LOCKOUT: locked=1; down-counter loaded with LOCKOUT_CYCLES on entry. Decrement each cycle; on reaching 0, fail_streak←0, locked←0, go IDLE.
- last_* and guess_value hold until the next accepted submit or reset.
- Reset mid-operation: immediate return to the reset state the following edge. cmp_enable drops, and no partial result is recorded.
- Latency counter is 8 bits; it never exceeds TIMEOUT_CYCLES, so there is no wrap.

## Timing
- Submit sampled high on edge 0 → cmp_enable high after edge 0 (visible cycle 1), guess_value valid the same cycle.
- cmp_enable is a registered output and is never combinational from inputs.
- The result edge and the first RELEASE cycle coincide: last_* update and cmp_enable falls after the same edge.
- Comparator responding k cycles after its first enabled cycle produces last_cycles = k+2, and the offset is constant. A full 8-bit match takes 5 comparator cycles, so last_cycles=7. An early-mismatch fail yields a strictly smaller last_cycles than a later one.
- Minimum submit-to-submit spacing is last_cycles+3 cycles. busy falls the cycle IDLE is re-entered.
- A LOCKOUT lasts exactly LOCKOUT_CYCLES cycles with locked=1.

## Test plan
- Reset: hold rst=0 4 cycles with submit toggling → all outputs 0, cmp_enable never rises.
- Full match: comparator model with secret 0xA5, guess 0xA5 → last_pass=1, last_cycles=7, fail_streak=0, attempts=1, busy low 3 cycles after result.
- Timing leak: secret 0xA5, guesses 0xA4, 0xA1, 0x85, 0x25 → fails with last_cycles 3,4,5,6 respectively.
- Lockout (MAX_FAILS=3, LOCKOUT_CYCLES=20): three wrong guesses → locked=1 for exactly 20 cycles; a submit pulse mid-lockout does not change attempts; afterwards fail_streak=0 and the next submit is accepted.
- Timeout (TIMEOUT_CYCLES=10), comparator flags held 0 → last_fail=1, last_timeout=1, last_cycles=10; stale cmp_success=1 held before submit is ignored for the first two enabled cycles.
- Corner cases: success and fail asserted together → pass recorded. Reset pulsed during WAIT → cmp_enable low next cycle and last_* remain 0. attempts preset near 0xFFFF wraps to 0 on the next submit.
